// File: rtl/led_pattern_seq.sv
// Programmable LED pattern sequencer: pattern RAM, prescaled step timer, run FSM.
// Define LED_SEQ_BOUNCE_EN to enable bounce (ping-pong) sequencing in mode 2.
module led_pattern_seq #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int LEDW  = 6,
    parameter int DIVW  = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pat_we,
    input  logic [AW-1:0]   pat_addr,
    input  logic [LEDW-1:0] pat_wdata,
    input  logic [AW-1:0]   len,
    input  logic [DIVW-1:0] div,
    input  logic [1:0]      mode,
    input  logic            start,
    input  logic            stop,
    output logic [LEDW-1:0] leds,
    output logic            busy,
    output logic            step_strobe,
    output logic            done
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   len_q, len_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [1:0]      mode_q, mode_d;
    logic [LEDW-1:0] leds_q, leds_d;
    logic            busy_q, busy_d;
    logic            strobe_q, strobe_d;
    logic            done_q, done_d;
    logic            dir_q, dir_d;
    logic [AW-1:0]   nxt_idx;
    logic            nxt_dir;
    logic [AW-1:0]   len_clamp;
    logic            at_last;
    logic            at_first;
    logic            is_oneshot;

    // Power-up contents are zero; reset intentionally leaves the RAM alone.
    logic [LEDW-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (pat_we && ({1'b0, pat_addr} < DEPTH_W)) begin
            mem[pat_addr[IW-1:0]] <= pat_wdata;
        end
    end

    assign len_clamp  = ({1'b0, len} > LAST_W) ? LAST_W[AW-1:0] : len;
    assign at_last    = (idx_q == len_q);
    assign at_first   = (idx_q == '0);
    assign is_oneshot = (mode_q == 2'd1);

    // Index/direction that the next step would move to.
    always_comb begin
        nxt_idx = at_last ? '0 : idx_q + 1'b1;
        nxt_dir = dir_q;
`ifdef LED_SEQ_BOUNCE_EN
        if (mode_q == 2'd2) begin
            if (len_q == '0) begin
                nxt_idx = '0;
                nxt_dir = 1'b0;
            end else if (!dir_q) begin
                if (at_last) begin
                    nxt_dir = 1'b1;
                    nxt_idx = idx_q - 1'b1;
                end else begin
                    nxt_idx = idx_q + 1'b1;
                end
            end else begin
                if (at_first) begin
                    nxt_dir = 1'b0;
                    nxt_idx = idx_q + 1'b1;
                end else begin
                    nxt_idx = idx_q - 1'b1;
                end
            end
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        div_d    = div_q;
        mode_d   = mode_q;
        leds_d   = leds_q;
        busy_d   = busy_q;
        dir_d    = dir_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        if (stop) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            leds_d  = '0;
            busy_d  = 1'b0;
            dir_d   = 1'b0;
        end else if (start) begin
            state_d = RUN;
            idx_d   = '0;
            cnt_d   = '0;
            dir_d   = 1'b0;
            len_d   = len_clamp;
            div_d   = div;
            mode_d  = mode;
            leds_d  = mem[0];
            busy_d  = 1'b1;
        end else if (state_q == RUN) begin
            if (cnt_q != div_q) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
                if (is_oneshot && at_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d    = nxt_idx;
                    dir_d    = nxt_dir;
                    leds_d   = mem[nxt_idx[IW-1:0]];
                    strobe_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            div_q    <= '0;
            mode_q   <= '0;
            leds_q   <= '0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            div_q    <= div_d;
            mode_q   <= mode_d;
            leds_q   <= leds_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

`ifdef LED_SEQ_BOUNCE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    assign dir_q = 1'b0;
`endif

    assign leds        = leds_q;
    assign busy        = busy_q;
    assign step_strobe = strobe_q;
    assign done        = done_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq (AW widened to 5 to reach len=20 / addr=16).
module tb_led_pattern_seq;

    typedef struct packed {
        logic [5:0] leds;
        logic       busy;
        logic       strobe;
        logic       done;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pat_we = 1'b0;
    logic [4:0]  pat_addr = '0;
    logic [5:0]  pat_wdata = '0;
    logic [4:0]  len = '0;
    logic [23:0] div = '0;
    logic [1:0]  mode = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [5:0]  leds;
    logic        busy;
    logic        step_strobe;
    logic        done;

    obs_t       q[$];
    obs_t       want;
    obs_t       got;
    logic [5:0] mem_m [16];
    int         errors = 0;
    int         checks = 0;

    led_pattern_seq #(.DEPTH(16), .AW(5), .LEDW(6), .DIVW(24)) dut (
        .clk(clk), .reset(reset), .pat_we(pat_we), .pat_addr(pat_addr),
        .pat_wdata(pat_wdata), .len(len), .div(div), .mode(mode),
        .start(start), .stop(stop), .leds(leds), .busy(busy),
        .step_strobe(step_strobe), .done(done)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic [5:0] l, logic b, logic s, logic d);
        obs_t o;
        o.leds = l; o.busy = b; o.strobe = s; o.done = d;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [5:0] d);
        pat_we = 1'b1; pat_addr = a; pat_wdata = d;
        tick();
        pat_we = 1'b0;
        if (a < 5'd16) mem_m[a[3:0]] = d;
    endtask

    task automatic go(input logic [4:0] l, input logic [23:0] dv, input logic [1:0] m);
        len = l; div = dv; mode = m; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        q.push_back(mk(6'h00, 0, 0, 0));
        want = q.pop_front(); got = {leds, busy, step_strobe, done}; checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset: got %h/%b%b%b want %h/%b%b%b", got.leds, got.busy, got.strobe, got.done, want.leds, want.busy, want.strobe, want.done);
        end
        reset = 1'b0;
    endtask

    task automatic test_loop();
        logic [5:0] seq [4];
        seq = '{6'h02, 6'h04, 6'h08, 6'h01};
        wr(0, 6'h01); wr(1, 6'h02); wr(2, 6'h04); wr(3, 6'h08);
        go(3, 2, 0);
        len = 1; div = 0; mode = 1;
        repeat (3) q.push_back(mk(6'h01, 1, 0, 0));
        for (int i = 0; i < 4; i++) begin
            q.push_back(mk(seq[i], 1, 1, 0));
            if (i < 3) repeat (2) q.push_back(mk(seq[i], 1, 0, 0));
        end
        for (int c = 0; q.size() > 0; c++) begin
            want = q.pop_front(); got = {leds, busy, step_strobe, done}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL loop c%0d: got %h/%b%b%b want %h/%b%b%b", c, got.leds, got.busy, got.strobe, got.done, want.leds, want.busy, want.strobe, want.done);
            end
            if (q.size() > 0) tick();
        end
        halt();
        got = {leds, busy, step_strobe, done}; want = mk(6'h00, 0, 0, 0); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL loop_stop: got %h/%b%b%b want 00/000", got.leds, got.busy, got.strobe, got.done);
        end
    endtask

    task automatic test_oneshot();
        go(3, 0, 1);
        q.push_back(mk(6'h01, 1, 0, 0));
        q.push_back(mk(6'h02, 1, 1, 0));
        q.push_back(mk(6'h04, 1, 1, 0));
        q.push_back(mk(6'h08, 1, 1, 0));
        q.push_back(mk(6'h08, 0, 0, 1));
        q.push_back(mk(6'h08, 0, 0, 0));
        q.push_back(mk(6'h08, 0, 0, 0));
        for (int c = 0; q.size() > 0; c++) begin
            want = q.pop_front(); got = {leds, busy, step_strobe, done}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL oneshot c%0d: got %h/%b%b%b want %h/%b%b%b", c, got.leds, got.busy, got.strobe, got.done, want.leds, want.busy, want.strobe, want.done);
            end
            if (q.size() > 0) tick();
        end
    endtask

    task automatic test_bounce();
        logic [5:0] seq [8];
`ifdef LED_SEQ_BOUNCE_EN
        seq = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h04, 6'h02, 6'h01, 6'h02};
`else
        seq = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h01, 6'h02, 6'h04, 6'h08};
`endif
        go(3, 0, 2);
        for (int i = 0; i < 8; i++) q.push_back(mk(seq[i], 1, i > 0, 0));
        for (int c = 0; q.size() > 0; c++) begin
            want = q.pop_front(); got = {leds, busy, step_strobe, done}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL bounce c%0d: got %h/%b%b%b want %h/%b%b%b", c, got.leds, got.busy, got.strobe, got.done, want.leds, want.busy, want.strobe, want.done);
            end
            if (q.size() > 0) tick();
        end
        halt();
    endtask

    task automatic test_start_stop();
        go(3, 0, 0);
        tick(); tick();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        q.push_back(mk(6'h00, 0, 0, 0));
        q.push_back(mk(6'h00, 0, 0, 0));
        for (int c = 0; q.size() > 0; c++) begin
            want = q.pop_front(); got = {leds, busy, step_strobe, done}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL start_stop c%0d: got %h/%b%b%b want %h/%b%b%b", c, got.leds, got.busy, got.strobe, got.done, want.leds, want.busy, want.strobe, want.done);
            end
            if (q.size() > 0) tick();
        end
        wr(15, 6'h2A);
        go(20, 0, 0);
        for (int i = 0; i < 19; i++) q.push_back(mk(mem_m[i % 16], 1, i > 0, 0));
        for (int c = 0; q.size() > 0; c++) begin
            want = q.pop_front(); got = {leds, busy, step_strobe, done}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL clamp c%0d: got %h/%b%b%b want %h/%b%b%b", c, got.leds, got.busy, got.strobe, got.done, want.leds, want.busy, want.strobe, want.done);
            end
            if (q.size() > 0) tick();
        end
        halt();
    endtask

    task automatic test_write_run();
        logic [5:0] disp;
        int         ix;
        disp = 6'h00;
        go(3, 3, 0);
        for (int c = 0; c < 30; c++) begin
            ix = (c / 4) % 4;
            if (c % 4 == 0) disp = mem_m[ix];
            q.push_back(mk(disp, 1, (c > 0) && (c % 4 == 0), 0));
            want = q.pop_front(); got = {leds, busy, step_strobe, done}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL write_run c%0d: got %h/%b%b%b want %h/%b%b%b", c, got.leds, got.busy, got.strobe, got.done, want.leds, want.busy, want.strobe, want.done);
            end
            pat_we = (c == 9) || (c == 10);
            pat_addr = (c == 9) ? 5'd2 : 5'd16;
            pat_wdata = (c == 9) ? 6'h3F : 6'h15;
            if (c == 9) mem_m[2] = 6'h3F;
            tick();
            pat_we = 1'b0;
        end
        halt();
    endtask

    task automatic test_reset_mid();
        go(3, 5, 0);
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.push_back(mk(6'h00, 0, 0, 0));
        want = q.pop_front(); got = {leds, busy, step_strobe, done}; checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_mid: got %h/%b%b%b want %h/%b%b%b", got.leds, got.busy, got.strobe, got.done, want.leds, want.busy, want.strobe, want.done);
        end
        go(3, 5, 0);
        repeat (6) q.push_back(mk(mem_m[0], 1, 0, 0));
        q.push_back(mk(mem_m[1], 1, 1, 0));
        for (int c = 0; q.size() > 0; c++) begin
            want = q.pop_front(); got = {leds, busy, step_strobe, done}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_restart c%0d: got %h/%b%b%b want %h/%b%b%b", c, got.leds, got.busy, got.strobe, got.done, want.leds, want.busy, want.strobe, want.done);
            end
            if (q.size() > 0) tick();
        end
        halt();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = 6'h00;
        test_reset();
        test_loop();
        test_oneshot();
        test_bounce();
        test_start_stop();
        test_write_run();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
